sram_march_bist_ctrl: RTL and testbench
=======================================

Name: sram_march_bist_ctrl

Overview:
- March C- memory BIST engine that drives the A_BIST_* port group of the single-port byte-mask SRAM macros, for example the 256x48 c2 variant.
- Sits directly upstream of the macro's BIST port, clocked by A_BIST_CLK.
- On START, sweeps every word, compares the macro's read data, and reports pass/fail, the first failing location and a failure count to the test/JTAG register block.

Parameters:
P_DATA_WIDTH, 48, SRAM word width
P_ADDR_WIDTH, 8, SRAM address width; depth N = 2**P_ADDR_WIDTH

Ports:
A_BIST_CLK  in  1  BIST clock, shared with the macro's A_BIST_CLK
A_BIST_RST_N  in  1  asynchronous active-low reset
START  in  1  single-cycle run request
A_BIST_EN  out  1  selects the macro's BIST port; high from run start until DONE
A_BIST_MEN  out  1  macro enable
A_BIST_WEN  out  1  write enable
A_BIST_REN  out  1  read enable
A_BIST_ADDR  out  P_ADDR_WIDTH  word address
A_BIST_DIN  out  P_DATA_WIDTH  write data
A_BIST_BM  out  P_DATA_WIDTH  bit mask
A_DOUT  in  P_DATA_WIDTH  macro read data, valid after the edge that sampled the read
DONE  out  1  run complete, held
FAIL  out  1  sticky mismatch flag
FAIL_ADDR  out  P_ADDR_WIDTH  address of first mismatch
FAIL_ELEM  out  3  march element index (0-5) of first mismatch
FAIL_COUNT  out  16  number of mismatching reads, saturates at 0xFFFF

Behaviour:
- Reset (asynchronous, A_BIST_RST_N low): every output is 0, state IDLE. Reset mid-run aborts immediately. No partial result is retained.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE -> RUN: on START=1 at a clock edge; the first op is driven after that edge.
- RUN issues exactly one op per cycle on A_BIST_*, all registered outputs:
  - A_BIST_MEN=1 for every op.
  - Write op: WEN=1, REN=0. Read op: REN=1, WEN=0. WEN and REN are never both 1.
  - A_BIST_BM is all ones for every op.
  - A_BIST_DIN: all zeros for a w0 op, all ones for a w1 op.
- March C- sequence, element index in brackets:
  - [0] up: w0
  - [1] up: r0, w1
  - [2] up: r1, w0
  - [3] down: r0, w1
  - [4] down: r1, w0
  - [5] up: r0
- Addressing:
  - Up elements run 0 to N-1; down elements run N-1 to 0.
  - Elements 1-4 apply read then write to the same address before advancing.
  - Total ops = 10N (2560 for N=256).
- RUN -> FLUSH: after the last op (r0 at N-1 in element 5). In FLUSH, MEN/WEN/REN=0 for one cycle while the last read is compared.
- FLUSH -> DONE: DONE=1 and A_BIST_EN=0. DONE is held until reset or a new START.
- DONE latency: DONE rises on the edge 10N+1 cycles after the START edge (2561 for N=256).
- Compare pipeline:
  - Each issued read registers a pending flag with its expected value (0s or 1s), address and element.
  - On the following edge, A_DOUT is compared against the expected value.
  - On mismatch: FAIL is set. FAIL_ADDR and FAIL_ELEM are captured only if FAIL was 0. FAIL_COUNT increments with saturation.
- Write ops and FLUSH-without-pending never trigger a compare.
- START handling:
  - START during RUN or FLUSH is ignored.
  - START in DONE clears DONE, FAIL, FAIL_ADDR, FAIL_ELEM and FAIL_COUNT, then enters RUN as from IDLE.
- A_BIST_EN is 1 throughout RUN and FLUSH.
- Counters: address counter is P_ADDR_WIDTH bits. Wrap detection uses terminal-count compare (N-1 going up, 0 going down), never overflow.

Test Plan:
- Fault-free 256x48 model, START pulse:
  - First op is w0 at ADDR 0x00.
  - Op 257 is r0 at 0x00, op 258 is w1 at 0x00.
  - Element 3 begins at ADDR 0xFF.
  - DONE=1 exactly 2561 cycles after the START edge.
  - FAIL=0, FAIL_COUNT=0.
- Model with bit 5 at address 0x37 stuck-at-1:
  - DONE=1, FAIL=1.
  - FAIL_ADDR=0x37, FAIL_ELEM=1.
  - FAIL_COUNT=3 (r0 fails in elements 1, 3 and 5).
- Model with address 0x80 stuck-at-0 on all bits:
  - FAIL_ADDR=0x80, FAIL_ELEM=2.
  - FAIL_COUNT=2 (r1 fails in elements 2 and 4).
- Assert A_BIST_RST_N low at cycle 1000 of a run:
  - All outputs are 0 asynchronously.
  - After release, state is IDLE; a new START yields the fault-free result.
- START pulses at cycles 10 and 2000 during a run:
  - Sequence is unaffected; DONE still rises at cycle 2561.
  - A START in DONE clears FAIL/FAIL_COUNT and reruns the full 2561-cycle sequence.
- Protocol checker over every run: WEN&REN never 1, BM always all-ones, MEN=1 only in RUN, A_BIST_EN=0 in IDLE and DONE.

Source files
------------

// File: rtl/sram_march_bist_ctrl.sv
// rtl/sram_march_bist_ctrl.sv - March C- BIST engine driving the A_BIST_* port of a byte-mask SRAM macro.
module sram_march_bist_ctrl #(
  parameter int P_DATA_WIDTH = 48,
  parameter int P_ADDR_WIDTH = 8
) (
  input  logic                    A_BIST_CLK,
  input  logic                    A_BIST_RST_N,
  input  logic                    START,
  output logic                    A_BIST_EN,
  output logic                    A_BIST_MEN,
  output logic                    A_BIST_WEN,
  output logic                    A_BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
  input  logic [P_DATA_WIDTH-1:0] A_DOUT,
  output logic                    DONE,
  output logic                    FAIL,
  output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [2:0]              FAIL_ELEM,
  output logic [15:0]             FAIL_COUNT
);

  localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE = {{(P_ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                    ph_q, ph_d;
  logic                    en_q, en_d, men_q, men_d, wen_q, wen_d, ren_q, ren_d;
  logic                    done_q, done_d;
  logic [P_DATA_WIDTH-1:0] din_q, din_d, bm_q, bm_d;
  logic                    issue, op_wr, clr_res;

  // cursor (elem, addr, phase) names the op currently on the port
  logic                    dual, down, at_term, last_op;
  logic [2:0]              seq_elem;
  logic [P_ADDR_WIDTH-1:0] seq_addr;
  logic                    seq_ph;

  logic                    pend_q, pend_exp_q, fail_q;
  logic [P_ADDR_WIDTH-1:0] pend_addr_q, fail_addr_q;
  logic [2:0]              pend_elem_q, fail_elem_q;
  logic [15:0]             fail_cnt_q;
  logic                    mismatch;

  assign dual    = (elem_q != 3'd0) && (elem_q != 3'd5);
  assign down    = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign at_term = down ? (addr_q == '0) : (addr_q == ADDR_MAX);
  assign last_op = (elem_q == 3'd5) && at_term;

  always_comb begin
    seq_elem = elem_q;
    seq_addr = addr_q;
    seq_ph   = 1'b0;
    if (dual && !ph_q) begin
      seq_ph = 1'b1;
    end else if (at_term) begin
      seq_elem = elem_q + 3'd1;
      seq_addr = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
    end else begin
      seq_addr = down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
    end
  end

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    ph_d    = ph_q;
    issue   = 1'b0;
    en_d    = 1'b0;
    done_d  = done_q;
    clr_res = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_RUN;
          elem_d  = 3'd0;
          addr_d  = '0;
          ph_d    = 1'b0;
          issue   = 1'b1;
          en_d    = 1'b1;
          done_d  = 1'b0;
          clr_res = 1'b1;
        end
      end
      S_RUN: begin
        en_d = 1'b1;
        if (last_op) begin
          state_d = S_FLUSH;
        end else begin
          elem_d = seq_elem;
          addr_d = seq_addr;
          ph_d   = seq_ph;
          issue  = 1'b1;
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // single-op elements are writes only in element 0; dual elements write in phase 1
    op_wr = (elem_d == 3'd0) || ph_d;
    men_d = issue;
    wen_d = issue && op_wr;
    ren_d = issue && !op_wr;
    din_d = (issue && op_wr && elem_d[0]) ? '1 : '0;
    bm_d  = issue ? '1 : '0;
  end

  always_ff @(posedge A_BIST_CLK or negedge A_BIST_RST_N) begin
    if (!A_BIST_RST_N) begin
      state_q <= S_IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
      ph_q    <= 1'b0;
      en_q    <= 1'b0;
      men_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      din_q   <= '0;
      bm_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      ph_q    <= ph_d;
      en_q    <= en_d;
      men_q   <= men_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      din_q   <= din_d;
      bm_q    <= bm_d;
      done_q  <= done_d;
    end
  end

  // a read on the port is sampled by the macro at the next edge; its data is checked one edge later
  assign mismatch = pend_q && (A_DOUT != {P_DATA_WIDTH{pend_exp_q}});

  always_ff @(posedge A_BIST_CLK or negedge A_BIST_RST_N) begin
    if (!A_BIST_RST_N) begin
      pend_q      <= 1'b0;
      pend_exp_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_elem_q <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_cnt_q  <= '0;
    end else begin
      pend_q      <= ren_q;
      pend_exp_q  <= ~elem_q[0];
      pend_addr_q <= addr_q;
      pend_elem_q <= elem_q;
      if (clr_res) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_elem_q <= '0;
        fail_cnt_q  <= '0;
      end else if (mismatch) begin
        fail_q <= 1'b1;
        if (!fail_q) begin
          fail_addr_q <= pend_addr_q;
          fail_elem_q <= pend_elem_q;
        end
        if (fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
      end
    end
  end

  assign A_BIST_EN   = en_q;
  assign A_BIST_MEN  = men_q;
  assign A_BIST_WEN  = wen_q;
  assign A_BIST_REN  = ren_q;
  assign A_BIST_ADDR = addr_q;
  assign A_BIST_DIN  = din_q;
  assign A_BIST_BM   = bm_q;
  assign DONE        = done_q;
  assign FAIL        = fail_q;
  assign FAIL_ADDR   = fail_addr_q;
  assign FAIL_ELEM   = fail_elem_q;
  assign FAIL_COUNT  = fail_cnt_q;

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// tb/tb_sram_march_bist_ctrl.sv - directed bench for sram_march_bist_ctrl with an SRAM fault model.
module tb_sram_march_bist_ctrl;

  localparam int W = 48;
  localparam int AW = 8;
  localparam int N = 256;
  localparam int LAT = 10 * N + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          bist_en, men, wen, ren, done, fail;
  logic [AW-1:0] addr, fail_addr;
  logic [W-1:0]  din, bm;
  logic [W-1:0]  dout = '0;
  logic [2:0]    fail_elem;
  logic [15:0]   fail_count;

  sram_march_bist_ctrl #(.P_DATA_WIDTH(W), .P_ADDR_WIDTH(AW)) dut (
    .A_BIST_CLK(clk), .A_BIST_RST_N(rst_n), .START(start),
    .A_BIST_EN(bist_en), .A_BIST_MEN(men), .A_BIST_WEN(wen), .A_BIST_REN(ren),
    .A_BIST_ADDR(addr), .A_BIST_DIN(din), .A_BIST_BM(bm), .A_DOUT(dout),
    .DONE(done), .FAIL(fail), .FAIL_ADDR(fail_addr), .FAIL_ELEM(fail_elem),
    .FAIL_COUNT(fail_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic wr; logic [AW-1:0] a; logic val; } op_t;
  typedef struct packed { int cyc; logic f; logic [AW-1:0] fa; logic [2:0] fe; logic [15:0] fc; } res_t;

  op_t  op_q[$];
  res_t res_q[$];
  int   n_asrt = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_events = 0;
  int   op_idx = 0;
  int   fault_mode = 0;
  logic done_prev = 1'b0;
  logic [W-1:0] mem [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: registered read, optional stuck-at faults applied on the read path
  always @(posedge clk) begin
    if (men && wen) mem[addr] <= din;
    if (men && ren) begin
      if (fault_mode == 1 && addr == 8'h37) dout <= mem[addr] | 48'h20;
      else if (fault_mode == 2 && addr == 8'h80) dout <= '0;
      else dout <= mem[addr];
    end
  end

  always @(negedge clk) begin
    if (rst_n && men) begin
      if (op_q.size() == 0) begin
        chk("op_unexpected", 64'(1), 64'(0));
      end else begin
        op_t e;
        e = op_q.pop_front();
        chk($sformatf("op%0d_wen", op_idx), 64'(wen), 64'(e.wr));
        chk($sformatf("op%0d_ren", op_idx), 64'(ren), 64'(!e.wr));
        chk($sformatf("op%0d_addr", op_idx), 64'(addr), 64'(e.a));
        if (e.wr) chk($sformatf("op%0d_din", op_idx), 64'(din), 64'({W{e.val}}));
        op_idx <= op_idx + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("proto_wen_ren", 64'(wen & ren), 64'(0));
      if (men) chk("proto_bm", 64'(bm), 64'({W{1'b1}}));
      if (!bist_en) chk("proto_men_wo_en", 64'(men), 64'(0));
      if (done) chk("proto_en_in_done", 64'(bist_en), 64'(0));
    end
  end

  always @(negedge clk) begin
    done_prev <= done;
    if (done && !done_prev) begin
      if (res_q.size() == 0) begin
        chk("done_unexpected", 64'(1), 64'(0));
      end else begin
        res_t r;
        r = res_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(r.cyc));
        chk("fail", 64'(fail), 64'(r.f));
        chk("fail_addr", 64'(fail_addr), 64'(r.fa));
        chk("fail_elem", 64'(fail_elem), 64'(r.fe));
        chk("fail_count", 64'(fail_count), 64'(r.fc));
      end
      done_events <= done_events + 1;
    end
  end

  task automatic push_ops();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        logic [AW-1:0] a;
        a = (e == 3 || e == 4) ? AW'(N - 1 - i) : AW'(i);
        case (e)
          0: op_q.push_back('{1'b1, a, 1'b0});
          1: begin op_q.push_back('{1'b0, a, 1'b0}); op_q.push_back('{1'b1, a, 1'b1}); end
          2: begin op_q.push_back('{1'b0, a, 1'b1}); op_q.push_back('{1'b1, a, 1'b0}); end
          3: begin op_q.push_back('{1'b0, a, 1'b0}); op_q.push_back('{1'b1, a, 1'b1}); end
          4: begin op_q.push_back('{1'b0, a, 1'b1}); op_q.push_back('{1'b1, a, 1'b0}); end
          default: op_q.push_back('{1'b0, a, 1'b0});
        endcase
      end
    end
  endtask

  // called at a negedge; START is sampled at the following posedge
  task automatic start_run(input logic f, input logic [AW-1:0] fa, input logic [2:0] fe, input logic [15:0] fc);
    push_ops();
    res_q.push_back('{cyc + 1 + LAT, f, fa, fe, fc});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int target;
    target = done_events + 1;
    for (int i = 0; i < LAT + 20 && done_events < target; i++) @(negedge clk);
    chk("done_timeout", 64'(done_events >= target), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en", 64'(bist_en), 64'(0));
    chk("rst_men", 64'(men), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_fail", 64'(fail), 64'(0));
    chk("rst_count", 64'(fail_count), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // fault-free run
    fault_mode = 0;
    start_run(1'b0, 8'h00, 3'd0, 16'd0);
    chk("run_en", 64'(bist_en), 64'(1));
    chk("run_done_low", 64'(done), 64'(0));
    wait_done();
    repeat (5) @(negedge clk);
    chk("done_held", 64'(done), 64'(1));
    chk("done_men", 64'(men), 64'(0));

    // bit 5 of word 0x37 stuck at 1: every r0 there fails
    fault_mode = 1;
    start_run(1'b1, 8'h37, 3'd1, 16'd3);
    wait_done();

    // word 0x80 stuck at 0: every r1 there fails; START in DONE clears old result
    fault_mode = 2;
    start_run(1'b1, 8'h80, 3'd2, 16'd2);
    chk("clr_done", 64'(done), 64'(0));
    chk("clr_fail", 64'(fail), 64'(0));
    chk("clr_count", 64'(fail_count), 64'(0));
    wait_done();

    // fault-free rerun from a failed DONE with stray STARTs mid-run
    fault_mode = 0;
    start_run(1'b0, 8'h00, 3'd0, 16'd0);
    repeat (9) @(negedge clk);
    pulse_start();
    repeat (1989) @(negedge clk);
    pulse_start();
    wait_done();

    // asynchronous reset mid-run, then a clean run
    start_run(1'b0, 8'h00, 3'd0, 16'd0);
    repeat (999) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", 64'(bist_en), 64'(0));
    chk("arst_men", 64'(men), 64'(0));
    chk("arst_wen", 64'(wen), 64'(0));
    chk("arst_ren", 64'(ren), 64'(0));
    chk("arst_addr", 64'(addr), 64'(0));
    chk("arst_din", 64'(din), 64'(0));
    chk("arst_bm", 64'(bm), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_fail", 64'({fail, fail_addr, fail_elem, fail_count}), 64'(0));
    op_q.delete();
    res_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_en", 64'(bist_en), 64'(0));
    chk("idle_men", 64'(men), 64'(0));
    chk("idle_done", 64'(done), 64'(0));
    start_run(1'b0, 8'h00, 3'd0, 16'd0);
    wait_done();
    repeat (3) @(negedge clk);
    chk("ops_consumed", 64'(op_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
